// File: rtl/noc_xbar_router.sv
// Buffered NPORTS x NPORTS crossbar router: per-input FIFOs, per-output round-robin arbiters, registered outputs.
// Optional per-output delivered-flit counters are compiled in when NOC_STATS_EN is defined.
module noc_xbar_router #(
    parameter int NPORTS = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NPORTS-1:0]              valid_i,
    output logic [NPORTS-1:0]              ready_o,
    input  logic [NPORTS-1:0][DATA_W-1:0]  data_i,
    output logic [NPORTS-1:0]              valid_o,
    input  logic [NPORTS-1:0]              ready_i,
    output logic [NPORTS-1:0][DATA_W-1:0]  data_o
`ifdef NOC_STATS_EN
    ,
    output logic [NPORTS-1:0][15:0]        flit_cnt_o
`endif
);

    localparam int DEST_W = $clog2(NPORTS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [DEST_W:0]   NPORTS_C = (DEST_W + 1)'(NPORTS);
    localparam logic [DEST_W-1:0] LAST_C   = DEST_W'(NPORTS - 1);

    logic [DATA_W-1:0] mem [NPORTS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NPORTS];
    logic [PTR_W-1:0]  rd_ptr [NPORTS];
    logic [CNT_W-1:0]  count [NPORTS];
    logic [DEST_W-1:0] rr_ptr [NPORTS];
    logic [DATA_W-1:0] head [NPORTS];
    logic [NPORTS-1:0] req [NPORTS];
    logic [DEST_W-1:0] gnt_idx [NPORTS];
    logic [NPORTS-1:0] push, pop, drop, gnt_vld;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            ready_o[p] = !rst && (count[p] < DEPTH_C);
            head[p]    = mem[p][rd_ptr[p]];
        end
        push = valid_i & ready_o;
    end

    // req[q][p]: head of FIFO p targets output q; out-of-range destinations are dropped instead
    always_comb begin : request
        logic [DEST_W-1:0] dest;
        logic              bad;
        logic              nonempty;
        dest     = '0;
        bad      = 1'b0;
        nonempty = 1'b0;
        drop     = '0;
        for (int q = 0; q < NPORTS; q++) begin
            req[q] = '0;
        end
        for (int p = 0; p < NPORTS; p++) begin
            dest     = head[p][DEST_W-1:0];
            bad      = {1'b0, dest} >= NPORTS_C;
            nonempty = count[p] != '0;
            drop[p]  = nonempty && bad;
            for (int q = 0; q < NPORTS; q++) begin
                req[q][p] = nonempty && !bad && (dest == DEST_W'(q));
            end
        end
    end

    always_comb begin : arbiter
        int idx;
        idx     = 0;
        gnt_vld = '0;
        for (int q = 0; q < NPORTS; q++) begin
            gnt_idx[q] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                idx = int'(rr_ptr[q]) + i;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                if ((!valid_o[q] || ready_i[q]) && !gnt_vld[q] && req[q][idx]) begin
                    gnt_vld[q] = 1'b1;
                    gnt_idx[q] = DEST_W'(idx);
                end
            end
        end
    end

    // Each head requests a single output, so at most one grant can name a given input
    always_comb begin
        pop = drop;
        for (int q = 0; q < NPORTS; q++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (gnt_vld[q] && (gnt_idx[q] == DEST_W'(p))) begin
                    pop[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= data_i[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                end
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CNT_W'(1);
                    2'b01:   count[p] <= count[p] - CNT_W'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // A stalled output (valid && !ready) receives no grant, so it simply holds
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= '0;
            data_o  <= '0;
            for (int q = 0; q < NPORTS; q++) begin
                rr_ptr[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NPORTS; q++) begin
                if (gnt_vld[q]) begin
                    valid_o[q] <= 1'b1;
                    data_o[q]  <= head[gnt_idx[q]];
                    rr_ptr[q]  <= (gnt_idx[q] == LAST_C) ? '0 : gnt_idx[q] + DEST_W'(1);
                end else if (ready_i[q]) begin
                    valid_o[q] <= 1'b0;
                end
            end
        end
    end

`ifdef NOC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_o <= '0;
        end else begin
            for (int q = 0; q < NPORTS; q++) begin
                if (valid_o[q] && ready_i[q] && (flit_cnt_o[q] != 16'hFFFF)) begin
                    flit_cnt_o[q] <= flit_cnt_o[q] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_xbar_router.sv
// Directed self-checking bench for noc_xbar_router (16 ports, 16-bit flits, depth 4).
// The saturation test of the delivered-flit counters runs only when NOC_STATS_EN is defined.
module tb_noc_xbar_router;

    localparam int NPORTS = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NPORTS-1:0]             valid_i;
    logic [NPORTS-1:0]             ready_o;
    logic [NPORTS-1:0][DATA_W-1:0] data_i;
    logic [NPORTS-1:0]             valid_o;
    logic [NPORTS-1:0]             ready_i;
    logic [NPORTS-1:0][DATA_W-1:0] data_o;
`ifdef NOC_STATS_EN
    logic [NPORTS-1:0][15:0]       flit_cnt_o;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    noc_xbar_router #(.NPORTS(NPORTS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o)
`ifdef NOC_STATS_EN
        ,
        .flit_cnt_o(flit_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NPORTS-1:0] v, input logic [NPORTS-1:0][DATA_W-1:0] d,
                                 input logic [NPORTS-1:0] r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] bp_flit(input int n);
        return {8'(n + 1), 8'h02};
    endfunction

    function automatic logic [15:0] perm_flit(input int p, input int seq);
        return {4'(p), 8'(seq), 4'((p + 1) % NPORTS)};
    endfunction

    initial begin
        int sent;
        int received;
        int total;
        logic acc;
        logic [NPORTS-1:0] acc_v;
        int sent_a [NPORTS];
        int recv_a [NPORTS];
        logic [NPORTS-1:0][DATA_W-1:0] d;

        rst = 1'b1;
        d   = '0;
        applyStimulus('0, d, '1);
        tick();
        tick();
        checkOutput("reset_valid_o", valid_o, '0);
        checkOutput("reset_data_o", data_o, '0);
        checkOutput("reset_ready_o", ready_o, '0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", ready_o, {NPORTS{1'b1}});

        $display("[TB] single flit 3 -> 5");
        d    = '0;
        d[3] = 16'hABC5;
        applyStimulus(16'h0008, d, '1);
        tick();
        applyStimulus('0, d, '1);
        checkOutput("single_not_yet", valid_o, '0);
        tick();
        checkOutput("single_valid", valid_o, 16'h0020);
        checkOutput("single_data", data_o[5], 16'hABC5);
        tick();
        checkOutput("single_cleared", valid_o, '0);
        checkOutput("single_data_hold", data_o[5], 16'hABC5);

        $display("[TB] contention 1,7,12 -> 5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d     = '0;
        d[1]  = 16'h1105;
        d[7]  = 16'h7705;
        d[12] = 16'hCC05;
        applyStimulus(16'h1082, d, '1);
        tick();
        applyStimulus('0, d, '1);
        tick();
        checkOutput("cont1_valid", valid_o, 16'h0020);
        checkOutput("cont1_first", data_o[5], 16'h1105);
        tick();
        checkOutput("cont1_second", data_o[5], 16'h7705);
        tick();
        checkOutput("cont1_third", data_o[5], 16'hCC05);
        checkOutput("cont1_valid3", valid_o, 16'h0020);
        tick();
        checkOutput("cont1_idle", valid_o, '0);
        d[1]  = 16'h2105;
        d[7]  = 16'h8705;
        d[12] = 16'hD005;
        applyStimulus(16'h1082, d, '1);
        tick();
        applyStimulus('0, d, '1);
        tick();
        checkOutput("cont2_first", data_o[5], 16'h2105);
        tick();
        checkOutput("cont2_second", data_o[5], 16'h8705);
        tick();
        checkOutput("cont2_third", data_o[5], 16'hD005);
        tick();
        checkOutput("cont2_idle", valid_o, '0);

        $display("[TB] backpressure input 0 -> output 2");
        ready_i[2] = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            acc        = ready_o[0];
            valid_i[0] = 1'b1;
            data_i[0]  = bp_flit(sent);
            tick();
            if (acc) sent++;
        end
        checkOutput("bp_accepted_blocked", sent, 5);
        checkOutput("bp_ready_low", ready_o[0], 1'b0);
        checkOutput("bp_hold_valid", valid_o[2], 1'b1);
        checkOutput("bp_hold_data", data_o[2], bp_flit(0));
        ready_i[2] = 1'b1;
        received = 0;
        for (int c = 0; c < 40 && received < 9; c++) begin
            if (valid_o[2]) begin
                checkOutput("bp_order", data_o[2], bp_flit(received));
                received++;
            end
            valid_i[0] = (sent < 9);
            data_i[0]  = bp_flit(sent);
            acc        = valid_i[0] && ready_o[0];
            tick();
            if (acc) sent++;
        end
        valid_i = '0;
        checkOutput("bp_received", received, 9);
        checkOutput("bp_idle", valid_o, '0);

        $display("[TB] permutation p -> p+1");
        for (int p = 0; p < NPORTS; p++) begin
            sent_a[p] = 0;
            recv_a[p] = 0;
        end
        for (int c = 0; c < 100; c++) begin
            for (int p = 0; p < NPORTS; p++) d[p] = perm_flit(p, sent_a[p]);
            applyStimulus('1, d, '1);
            acc_v = ready_o;
            tick();
            for (int p = 0; p < NPORTS; p++) if (acc_v[p]) sent_a[p]++;
            if (c >= 1) checkOutput("perm_all_valid", valid_o, {NPORTS{1'b1}});
            for (int q = 0; q < NPORTS; q++) begin
                if (valid_o[q]) begin
                    checkOutput("perm_data", data_o[q], perm_flit((q + NPORTS - 1) % NPORTS, recv_a[q]));
                    recv_a[q]++;
                end
            end
        end
        valid_i = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int q = 0; q < NPORTS; q++) begin
                if (valid_o[q]) begin
                    checkOutput("perm_drain", data_o[q], perm_flit((q + NPORTS - 1) % NPORTS, recv_a[q]));
                    recv_a[q]++;
                end
            end
        end
        total = 0;
        for (int q = 0; q < NPORTS; q++) total += recv_a[q];
        checkOutput("perm_total", total, 1600);

        $display("[TB] reset mid-stream");
        for (int p = 0; p < NPORTS; p++) d[p] = {4'(p), 8'h77, 4'(p)};
        applyStimulus('1, d, '0);
        tick();
        tick();
        tick();
        applyStimulus('0, d, '0);
        rst = 1'b1;
        tick();
        checkOutput("midrst_valid", valid_o, '0);
        checkOutput("midrst_data", data_o, '0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", ready_o, {NPORTS{1'b1}});
        ready_i = '1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("midrst_no_stale", valid_o, '0);
        end

`ifdef NOC_STATS_EN
        $display("[TB] flit counter saturation");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("stats_reset", flit_cnt_o, '0);
        sent = 0;
        for (int c = 0; c < 70000 && sent < 65540; c++) begin
            valid_i[0] = 1'b1;
            data_i[0]  = 16'h5A50;
            acc        = ready_o[0];
            tick();
            if (acc) sent++;
        end
        valid_i = '0;
        tick();
        tick();
        tick();
        checkOutput("stats_sent", sent, 65540);
        checkOutput("stats_sat", flit_cnt_o[0], 16'hFFFF);
        checkOutput("stats_other", flit_cnt_o[1], 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/noc_xbar_router.md
# noc_xbar_router

Parametrised, buffered crossbar router for the on-chip network: the next generation of the 16-port NoC. It is generalised in port count, flit width and buffer depth, and it adds valid/ready backpressure on both sides. Each input port has a FIFO. Each output port has its own round-robin arbiter and a registered output stage. The destination port is carried in the low bits of every flit, so one flit moves from any input to any output.

## Interface
Parameters:
- NPORTS, 16, number of input ports and of output ports (≥2)
- DATA_W, 16, flit width in bits (≥ DEST_W)
- DEPTH, 4, input FIFO depth in flits, power of two, ≥2
- DEST_W, $clog2(NPORTS), derived, never overridden

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- valid_i  input  [NPORTS]  flit offered on input p
- ready_o  output  [NPORTS]  input p can accept
- data_i  input  [NPORTS][DATA_W]  input flits; bits [DEST_W-1:0] hold the destination port
- valid_o  output  [NPORTS]  flit present on output q
- ready_i  input  [NPORTS]  sink at output q accepts
- data_o  output  [NPORTS][DATA_W]  output flits, passed through unmodified
- flit_cnt_o  output  [NPORTS][16]  delivered-flit count per output; present only with NOC_STATS_EN

## Operation
- **Input accept:** a flit is accepted on input p when valid_i[p] && ready_o[p]. It is written into FIFO p.
  - ready_o[p] = !rst && (count[p] < DEPTH).
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- **Request:** FIFO head of input p requests output q = head[DEST_W-1:0].
  - A destination ≥ NPORTS, possible only when NPORTS is not a power of two, is popped and discarded.
- **Output stage:** output register q is free when !valid_o[q] || ready_i[q].
- **Arbitration:** when output q is free, its arbiter grants one requesting input, searching round-robin from rr_ptr[q] upward with wrap at NPORTS.
  - The granted head is popped and loaded into data_o[q], and valid_o[q] is set.
  - rr_ptr[q] becomes (grant+1) mod NPORTS.
  - With no requester and ready_i[q] asserted, valid_o[q] clears. data_o[q] holds its last value.
- **One pop per head:** a FIFO head requests only one output, so each input pops at most once per cycle. No input is granted by two outputs.
- **Hold under backpressure:** while valid_o[q] && !ready_i[q], data_o[q] and valid_o[q] stay stable. Arbiter q grants nothing.
- **Ordering:** flits from input p to output q are delivered in acceptance order. There is no ordering guarantee across different inputs.
- **Head-of-line blocking:** a blocked head stalls its whole FIFO. There is no virtual-channel bypass.

## Timing
- **Reset:** FIFOs empty, every rr_ptr = 0, valid_o = 0, data_o = 0, ready_o = 0 while rst = 1. flit_cnt_o = 0 when enabled.
- ready_o returns to 1 in the first cycle after rst deasserts.
- **Latency:** a flit accepted at edge E0 on an idle path is granted at E1. valid_o is high after E1, so minimum latency is 2 cycles.
- **Throughput:** one flit per output per cycle with ready_i held at 1. This allows full permutation bandwidth.
- **Reset mid-operation:** in-flight and buffered flits are discarded, with no partial delivery. valid_o drops at the reset edge.
- **Simultaneous events:** push and pop of the same FIFO in one cycle leave count unchanged. A grant to output q and consumption of the old valid_o[q] in the same cycle loads the new flit with no bubble.
- **Wrap-around:** FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Configuration
- **NOC_STATS_EN defined:**
  - flit_cnt_o exists.
  - flit_cnt_o[q] increments on each valid_o[q] && ready_i[q].
  - It saturates at 16'hFFFF and clears only on rst.
- **NOC_STATS_EN undefined:** the flit_cnt_o port and its counters are absent. Datapath behaviour is identical.

## Test plan
- **Single flit:** input 3 sends 16'hABC5 with ready_i all 1. valid_o[5] is high exactly 2 cycles after acceptance, data_o[5] = 16'hABC5, and no other valid_o asserts.
- **Contention:** inputs 1, 7 and 12 each send one flit to output 5 in the same cycle, starting from reset. Output 5 delivers them in order 1, 7, 12 on consecutive cycles. A second identical burst delivers 1, 7, 12 again, because the pointer wrapped past 12.
- **Backpressure:**
  - Hold ready_i[2] = 0 and stream 9 flits from input 0 to output 2. With DEPTH = 4, ready_o[0] falls after 5 flits are accepted: 1 in the output register and 4 in the FIFO.
  - Release ready_i[2]. All accepted flits emerge in order.
- **Permutation:** each input p streams to output (p+1) mod 16 for 100 cycles. After the 2-cycle fill, every valid_o is high every cycle and there is no loss or reorder.
- **Reset mid-stream:** assert rst for 1 cycle with FIFOs half full. The next cycle has valid_o = 0 and data_o = 0, and ready_o is all 1. No stale flit ever appears afterwards.
- **NOC_STATS_EN:** deliver 65540 flits to output 0. flit_cnt_o[0] reads 16'hFFFF, and flit_cnt_o[1] = 0.
